// File: rtl/image_proc_pkg.sv
// Shared constants for the image frame scheduler: FSM encoding, processing-mode codes
// and default frame geometry.
package image_proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LINE   = 2'd1,
        ST_HBLANK = 2'd2,
        ST_FDONE  = 2'd3
    } sched_state_t;

    localparam logic [1:0] OP_PASS   = 2'd0;
    localparam logic [1:0] OP_BRIGHT = 2'd1;
    localparam logic [1:0] OP_GRAY   = 2'd2;
    localparam logic [1:0] OP_THRESH = 2'd3;

    localparam int DEF_WIDTH  = 768;
    localparam int DEF_HEIGHT = 512;
    localparam int DEF_HBLANK = 16;

endpackage

// File: rtl/image_pixel_counter.sv
// Column/row/linear-address counters for the frame scheduler.
// The address is kept by incrementing alongside col/row, so no multiplier is needed.
module image_pixel_counter
    import image_proc_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = 19,
    parameter int ROW_W  = 10,
    parameter int COL_W  = 11
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              clr,
    input  logic              inc,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_pix
);

    assign last_col = (col == COL_W'(WIDTH - 1));
    assign last_pix = last_col && (row == ROW_W'(HEIGHT - 1));

    always_ff @(posedge HCLK) begin
        if (HRESET || clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
            if (last_col) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_frame_scheduler.sv
// Frame-level pixel sequencer: streams addr/row/col with ready/valid backpressure,
// inserts line blanking, generates HSYNC/VSYNC and latches op_sel per frame.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for start; outputs quiet
//   ST_LINE   | presenting pixels of the current line (HSYNC high)
//   ST_HBLANK | HBLANK idle cycles between lines
//   ST_FDONE  | one-cycle frame_done pulse, counters cleared after
module image_frame_scheduler
    import image_proc_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int HBLANK = DEF_HBLANK,
    parameter int ADDR_W = 19,
    parameter int ROW_W  = 10,
    parameter int COL_W  = 11
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        op_sel,
    input  logic              pix_ready,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [1:0]        op_latched,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              busy,
    output logic              frame_done
);

    localparam int HB_W    = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam int HB_LAST = (HBLANK > 0) ? HBLANK - 1 : 0;

    sched_state_t    state, state_nxt;
    logic [HB_W-1:0] hb_cnt;
    logic            vsync_pend;
    logic            accept;
    logic            cnt_inc;
    logic            cnt_clr;
    logic            last_col;
    logic            last_pix;

    image_pixel_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_pixel_counter (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .col      (col),
        .row      (row),
        .addr     (addr),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    assign pix_valid  = (state == ST_LINE);
    assign HSYNC      = (state == ST_LINE);
    assign VSYNC      = pix_valid && vsync_pend;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_FDONE);
    assign accept     = pix_valid && pix_ready;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_LINE;
                    cnt_clr   = 1'b1;
                end
            end
            ST_LINE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_clr   = 1'b1;
                end else if (accept) begin
                    // last pixel is held on the outputs through the FDONE cycle
                    if (last_pix) begin
                        state_nxt = ST_FDONE;
                    end else begin
                        cnt_inc = 1'b1;
                        if (last_col && (HBLANK > 0)) begin
                            state_nxt = ST_HBLANK;
                        end
                    end
                end
            end
            ST_HBLANK: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_clr   = 1'b1;
                end else if (hb_cnt == HB_W'(HB_LAST)) begin
                    state_nxt = ST_LINE;
                end
            end
            ST_FDONE: begin
                state_nxt = ST_IDLE;
                cnt_clr   = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hb_cnt     <= '0;
            vsync_pend <= 1'b0;
            op_latched <= 2'd0;
        end else begin
            hb_cnt <= (state == ST_HBLANK) ? hb_cnt + 1'b1 : '0;
            if (state == ST_IDLE && state_nxt == ST_LINE) begin
                op_latched <= op_sel;
                vsync_pend <= 1'b1;
            end else if (accept || state_nxt == ST_IDLE) begin
                vsync_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_image_frame_scheduler.sv
// Bench for image_frame_scheduler: directed frame scenarios plus random traffic on two
// configurations, every cycle compared against a pixel-index reference model.
module tb_image_frame_scheduler;
    import image_proc_pkg::*;

    localparam int NI     = 2;
    localparam int ADDR_W = 19;
    localparam int ROW_W  = 10;
    localparam int COL_W  = 11;

    function automatic int fw(int i);  return 4;                  endfunction
    function automatic int fh(int i);  return (i == 0) ? 3 : 2;   endfunction
    function automatic int fhb(int i); return (i == 0) ? 2 : 0;   endfunction

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    logic              start_v [NI];
    logic              abort_v [NI];
    logic              ready_v [NI];
    logic [1:0]        op_v    [NI];
    logic              pv_o    [NI];
    logic              hs_o    [NI];
    logic              vs_o    [NI];
    logic              busy_o  [NI];
    logic              fd_o    [NI];
    logic [ADDR_W-1:0] addr_o  [NI];
    logic [ROW_W-1:0]  row_o   [NI];
    logic [COL_W-1:0]  col_o   [NI];
    logic [1:0]        opl_o   [NI];

    image_frame_scheduler #(.WIDTH(4), .HEIGHT(3), .HBLANK(2),
                            .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start_v[0]), .abort(abort_v[0]),
        .op_sel(op_v[0]), .pix_ready(ready_v[0]), .pix_valid(pv_o[0]),
        .addr(addr_o[0]), .row(row_o[0]), .col(col_o[0]), .op_latched(opl_o[0]),
        .HSYNC(hs_o[0]), .VSYNC(vs_o[0]), .busy(busy_o[0]), .frame_done(fd_o[0])
    );

    image_frame_scheduler #(.WIDTH(4), .HEIGHT(2), .HBLANK(0),
                            .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W)) dut_nb (
        .HCLK(HCLK), .HRESET(HRESET), .start(start_v[1]), .abort(abort_v[1]),
        .op_sel(op_v[1]), .pix_ready(ready_v[1]), .pix_valid(pv_o[1]),
        .addr(addr_o[1]), .row(row_o[1]), .col(col_o[1]), .op_latched(opl_o[1]),
        .HSYNC(hs_o[1]), .VSYNC(vs_o[1]), .busy(busy_o[1]), .frame_done(fd_o[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference: frame position as a plain pixel index plus remaining blank cycles
    bit       m_act   [NI];
    int       m_p     [NI];
    int       m_blank [NI];
    bit       m_done  [NI];
    bit       m_first [NI];
    bit [1:0] m_op    [NI];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            if (HRESET) begin
                m_act[i] = 0; m_p[i] = 0; m_blank[i] = 0;
                m_done[i] = 0; m_first[i] = 0; m_op[i] = 2'd0;
            end else if (!m_act[i]) begin
                if (start_v[i] && !abort_v[i]) begin
                    m_act[i] = 1; m_p[i] = 0; m_op[i] = op_v[i]; m_first[i] = 1;
                end
            end else if (abort_v[i]) begin
                m_act[i] = 0; m_p[i] = 0; m_blank[i] = 0; m_done[i] = 0; m_first[i] = 0;
            end else if (m_done[i]) begin
                m_act[i] = 0; m_done[i] = 0; m_p[i] = 0;
            end else if (m_blank[i] > 0) begin
                m_blank[i]--;
            end else if (ready_v[i]) begin
                m_first[i] = 0;
                if (m_p[i] == fw(i) * fh(i) - 1) begin
                    m_done[i] = 1;
                end else begin
                    m_p[i]++;
                    if (m_p[i] % fw(i) == 0) m_blank[i] = fhb(i);
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            bit exp_pv;
            exp_pv = m_act[i] && !m_done[i] && (m_blank[i] == 0);
            chk($sformatf("u%0d_pix_valid", i), 32'(pv_o[i]), 32'(exp_pv));
            chk($sformatf("u%0d_HSYNC", i), 32'(hs_o[i]), 32'(exp_pv));
            chk($sformatf("u%0d_VSYNC", i), 32'(vs_o[i]), 32'(exp_pv && m_first[i]));
            chk($sformatf("u%0d_busy", i), 32'(busy_o[i]), 32'(m_act[i]));
            chk($sformatf("u%0d_frame_done", i), 32'(fd_o[i]), 32'(m_done[i]));
            chk($sformatf("u%0d_addr", i), 32'(addr_o[i]), 32'(m_p[i]));
            chk($sformatf("u%0d_row", i), 32'(row_o[i]), 32'(m_p[i] / fw(i)));
            chk($sformatf("u%0d_col", i), 32'(col_o[i]), 32'(m_p[i] % fw(i)));
            chk($sformatf("u%0d_op_latched", i), 32'(opl_o[i]), 32'(m_op[i]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge HCLK);
        #1;
        compare_all();
    endtask

    // Runs one frame on unit i; optional 3-cycle stall at stall_addr, optional
    // op_sel change plus stray start pulse poke_at cycles after start.
    task automatic run_frame(input int i, input int stall_addr, input int poke_at,
                             output int lat);
        bit stalled = 0;
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
        lat = 1;
        while (!fd_o[i] && lat < 200) begin
            if (stall_addr >= 0 && !stalled && pv_o[i] && addr_o[i] == ADDR_W'(stall_addr)) begin
                stalled = 1;
                ready_v[i] = 1'b0;
                repeat (3) begin
                    tick(); lat++;
                    chk("stall_addr", 32'(addr_o[i]), 32'(stall_addr));
                    chk("stall_row", 32'(row_o[i]), 32'(stall_addr / fw(i)));
                    chk("stall_col", 32'(col_o[i]), 32'(stall_addr % fw(i)));
                end
                ready_v[i] = 1'b1;
            end else if (lat == poke_at) begin
                op_v[i] = OP_BRIGHT;
                start_v[i] = 1'b1;
                tick(); lat++;
                start_v[i] = 1'b0;
                chk("poke_op_latched", 32'(opl_o[i]), 32'(OP_GRAY));
            end else begin
                tick(); lat++;
            end
        end
        chk("frame_done_seen", 32'(fd_o[i]), 32'd1);
        tick();
    endtask

    initial begin
        int lat;
        int n;
        HRESET = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0; ready_v[i] = 1'b1; op_v[i] = OP_PASS;
        end
        tick(); tick();
        chk("reset_busy", 32'(busy_o[0]), 32'd0);
        chk("reset_addr", 32'(addr_o[0]), 32'd0);
        HRESET = 1'b0;
        tick();

        // plain frame, op grayscale
        op_v[0] = OP_GRAY;
        run_frame(0, -1, -1, lat);
        chk("s1_latency", 32'(lat), 32'd17);
        chk("s1_op_latched", 32'(opl_o[0]), 32'(OP_GRAY));

        // 3-cycle stall at addr 5
        run_frame(0, 5, -1, lat);
        chk("s2_latency", 32'(lat), 32'd20);

        // op change and start mid-frame are ignored
        op_v[0] = OP_GRAY;
        run_frame(0, -1, 5, lat);
        chk("s3_latency", 32'(lat), 32'd17);
        op_v[0] = OP_THRESH;

        // abort at addr 6
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        n = 0;
        while (!(pv_o[0] && addr_o[0] == ADDR_W'(6)) && n < 50) begin tick(); n++; end
        chk("s4_reached_addr6", 32'(addr_o[0]), 32'd6);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        chk("s4_busy", 32'(busy_o[0]), 32'd0);
        chk("s4_pix_valid", 32'(pv_o[0]), 32'd0);
        chk("s4_addr", 32'(addr_o[0]), 32'd0);
        repeat (20) begin
            tick();
            chk("s4_no_done", 32'(fd_o[0]), 32'd0);
        end
        run_frame(0, -1, -1, lat);
        chk("s4_restart_latency", 32'(lat), 32'd17);
        chk("s4_restart_op", 32'(opl_o[0]), 32'(OP_THRESH));

        // reset mid-HBLANK, then start+abort in IDLE
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        n = 0;
        while (!(busy_o[0] && !pv_o[0]) && n < 50) begin tick(); n++; end
        chk("s5_in_hblank", 32'(hs_o[0]), 32'd0);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk("s5_busy", 32'(busy_o[0]), 32'd0);
        chk("s5_addr", 32'(addr_o[0]), 32'd0);
        chk("s5_op_latched", 32'(opl_o[0]), 32'd0);
        chk("s5_pix_valid", 32'(pv_o[0]), 32'd0);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("s5_start_abort_busy", 32'(busy_o[0]), 32'd0);
        tick();
        chk("s5_still_idle", 32'(busy_o[0]), 32'd0);

        // no blanking: back-to-back lines
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        n = 0;
        while (pv_o[1] && hs_o[1] && n < 20) begin n++; tick(); end
        chk("s6_valid_run", 32'(n), 32'd8);
        chk("s6_done_9th", 32'(fd_o[1]), 32'd1);
        tick();

        // random traffic on both units
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NI; i++) begin
                ready_v[i] = ($urandom_range(0, 3) != 0);
                start_v[i] = ($urandom_range(0, 9) == 0);
                abort_v[i] = ($urandom_range(0, 59) == 0);
                op_v[i]    = 2'($urandom_range(0, 3));
            end
            HRESET = ($urandom_range(0, 249) == 0);
            tick();
        end
        HRESET = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0; ready_v[i] = 1'b1;
        end
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
